// File: rtl/mem_io_responder.sv
// Bus target for the CPU: byte RAM, UART-style I/O window at 0x30000-0x30007,
// free-running cycle counter with snapshot, and tx back-pressure flag.
module mem_io_responder #(
  parameter int unsigned RAM_ADDR_W  = 17,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop
);

  localparam int unsigned TPW = $clog2(TX_DEPTH);
  localparam int unsigned RPW = $clog2(RX_DEPTH);
  localparam logic [TPW:0] TX_DEPTH_C = (TPW+1)'(TX_DEPTH);
  localparam logic [RPW:0] RX_DEPTH_C = (RPW+1)'(RX_DEPTH);
  localparam logic [TPW:0] TX_FULL_AT =
    (FULL_MARGIN >= TX_DEPTH) ? '0 : (TPW+1)'(TX_DEPTH - FULL_MARGIN);

  logic [7:0] ram    [2**RAM_ADDR_W];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [TPW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TPW:0]   tx_cnt_q, tx_cnt_d;
  logic [RPW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RPW:0]   rx_cnt_q, rx_cnt_d;
  logic [31:0]    cnt_q, cnt_d, snap_q, snap_d;
  logic [7:0]     din_q, din_d;
  logic           stop_q, stop_d, full_q, full_d;

  logic       is_io, rd_acc, wr_acc;
  logic [2:0] off;
  logic       tx_push, tx_push_ok, tx_pop, rx_push, rx_pop;
  logic [7:0] tx_wdata;
  logic       unused_addr;

  assign is_io       = (mem_a[17:16] == 2'b11);
  assign off         = mem_a[2:0];
  assign rd_acc      = rdy_in & ~mem_wr;
  assign wr_acc      = rdy_in & mem_wr;
  assign unused_addr = ^mem_a;

  assign mem_din        = din_q;
  assign io_buffer_full = full_q;
  assign program_stop   = stop_q;
  assign tx_valid       = (tx_cnt_q != '0);
  assign tx_data        = tx_mem[tx_rp_q];
  assign rx_ready       = (rx_cnt_q != RX_DEPTH_C);

  always_comb begin
    tx_push  = 1'b0;
    tx_wdata = mem_dout;
    if (wr_acc && is_io && !stop_q) begin
      if (off == 3'd0 && mem_dout != '0) begin
        tx_push = 1'b1;
      end else if (off == 3'd4) begin
        tx_push  = 1'b1;
        tx_wdata = '0;
      end
    end
    tx_pop     = tx_valid & tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    tx_push_ok = tx_push && ((tx_cnt_q != TX_DEPTH_C) || tx_pop);
    rx_push    = rx_valid & rx_ready;
    rx_pop     = rd_acc && is_io && (off == 3'd0) && (rx_cnt_q != '0);

    tx_wp_d  = tx_wp_q + TPW'(tx_push_ok);
    tx_rp_d  = tx_rp_q + TPW'(tx_pop);
    tx_cnt_d = tx_cnt_q + (TPW+1)'(tx_push_ok) - (TPW+1)'(tx_pop);
    rx_wp_d  = rx_wp_q + RPW'(rx_push);
    rx_rp_d  = rx_rp_q + RPW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (RPW+1)'(rx_push) - (RPW+1)'(rx_pop);
    full_d   = (tx_cnt_d >= TX_FULL_AT);
    stop_d   = stop_q | (wr_acc && is_io && (off == 3'd4));
    cnt_d    = rdy_in ? cnt_q + 32'd1 : cnt_q;

    snap_d = snap_q;
    din_d  = din_q;
    if (rd_acc) begin
      if (is_io) begin
        case (off)
          3'd0:    din_d = (rx_cnt_q != '0) ? rx_mem[rx_rp_q] : '0;
          3'd4: begin
            snap_d = cnt_q;
            din_d  = cnt_q[7:0];
          end
          3'd5:    din_d = snap_q[15:8];
          3'd6:    din_d = snap_q[23:16];
          3'd7:    din_d = snap_q[31:24];
          default: din_d = '0;
        endcase
      end else begin
        din_d = ram[mem_a[RAM_ADDR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      cnt_q    <= '0;
      snap_q   <= '0;
      din_q    <= '0;
      stop_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      din_q    <= din_d;
      stop_q   <= stop_d;
      full_q   <= full_d;
    end
  end

  // Storage is never reset; pointers alone define FIFO contents.
  always_ff @(posedge clk_in) begin
    if (rst_in && wr_acc && !is_io) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
    if (rst_in && tx_push_ok) tx_mem[tx_wp_q] <= tx_wdata;
    if (rst_in && rx_push) rx_mem[rx_wp_q] <= rx_data;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target-side responder for the CPU's byte-wide memory bus (mem_a / mem_dout / mem_wr driven by the CPU, mem_din returned to it).
- Provides byte RAM, a UART-style I/O window at 0x30000–0x30007, the free-running cycle counter, and the io_buffer_full back-pressure flag.
- Instantiated beside cpu in the top-level and in simulation benches.

Parameters:
RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB)
TX_DEPTH, 8, tx FIFO depth in bytes (power of two, >= 4)
RX_DEPTH, 8, rx FIFO depth in bytes (power of two, >= 2)
FULL_MARGIN, 2, free tx slots at or below which io_buffer_full asserts

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  bus accept enable; when low no access is accepted and the counter holds
mem_a  input  32  byte address from CPU (bits 17:0 decoded)
mem_dout  input  8  write data from CPU
mem_wr  input  1  1 = write, 0 = read
mem_din  output  8  read data to CPU
io_buffer_full  output  1  tx FIFO nearly full
tx_data  output  8  byte toward UART transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART consumes tx_data
rx_data  input  8  byte from UART receiver
rx_valid  input  1  rx_data valid
rx_ready  output  1  rx FIFO can accept
program_stop  output  1  sticky: program wrote 0x30004

Behaviour:
- Reset (rst_in low, asynchronous): mem_din=0, both FIFOs empty, tx_valid=0, rx_ready=1, io_buffer_full=0, program_stop=0, cycle counter=0, counter snapshot=0. RAM contents are not reset.
- Access accepted on a posedge when rdy_in=1. Every such cycle is an access; there is no idle encoding.
- Decode:
  - mem_a[17:16]==2'b11 → I/O, offset mem_a[2:0].
  - Otherwise → RAM at mem_a[RAM_ADDR_W-1:0] (upper bits truncated, wraps).
- RAM read: mem_din = RAM byte, registered; valid the cycle after acceptance, held until the next accepted read.
- RAM write: stored at acceptance; mem_din unchanged.
- I/O reads (result registered, same timing as RAM):
  - Offset 0: if rx FIFO non-empty, pop head and return it; if empty, return 0x00 with no pop. Each accepted read cycle pops once.
  - Offset 4: latch counter into snapshot; return snapshot[7:0] taken from the pre-increment counter value.
  - Offsets 5/6/7: return snapshot bytes 1/2/3; no re-latch.
  - Other offsets: return 0x00.
- I/O writes:
  - Offset 0: nonzero data is pushed to tx FIFO; 0x00 is ignored.
  - Offset 4: push 0x00 to tx FIFO and set program_stop (sticky until reset).
  - Other offsets: ignored.
  - After program_stop=1, all I/O writes are ignored; RAM remains fully functional.
- tx FIFO:
  - tx_valid = non-empty; tx_data = head.
  - Pop when tx_valid && tx_ready, independent of rdy_in.
  - Push while full with a same-cycle pop is accepted. Push while full without a pop is dropped silently.
  - Count stays within 0..TX_DEPTH; pointers wrap modulo TX_DEPTH.
- io_buffer_full = (TX_DEPTH − count) <= FULL_MARGIN, registered from the post-update count.
- rx FIFO:
  - rx_ready = not full.
  - Push when rx_valid && rx_ready, independent of rdy_in.
  - Same-cycle push into an empty FIFO plus a 0x30000 read: read returns 0x00 (no bypass) and the byte is stored.
  - Simultaneous push and pop when non-empty keeps the count.
- Cycle counter: 32-bit, +1 every posedge with rdy_in=1, wraps 0xFFFFFFFF→0.
- rdy_in low: no RAM or I/O access, no snapshot latch, counter holds, mem_din holds. FIFO handshakes on the UART side continue.
- Reset asserted mid-operation: all state above clears immediately, and any in-flight pop or push is discarded.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 → mem_din=0xA5 exactly one cycle after the read is accepted. Read 0x20010 (wraps) → 0xA5.
- With tx_ready=0, write 0x41, 0x00, 0x42 to 0x30000 → FIFO holds 0x41, 0x42 only. Fill to TX_DEPTH−2 → io_buffer_full=1 the following cycle. Further pushes at full are dropped. Set tx_ready=1 → bytes emerge in order.
- Push 0x31, 0x32 via rx handshake; read 0x30000 three times → 0x31, 0x32, 0x00. With RX_DEPTH bytes queued → rx_ready=0.
- After 100 cycles with rdy_in=1, read 0x30004..0x30007 → bytes form the snapshot (=100 − pipeline offset, checked against the model). Hold rdy_in=0 for 20 cycles → counter unchanged.
- Write any value to 0x30004 → program_stop=1 and a 0x00 byte on tx. A later write of 0x55 to 0x30000 → no tx push. A RAM write/read still works.
- Assert rst_in low with tx/rx FIFOs non-empty and counter at 50 → all outputs return to reset values asynchronously. RAM still holds previously written data.
